// File: rtl/uart_dmi_sequencer_pkg.sv
// Shared types for the UART-to-DMI command sequencer: DMI payload layouts,
// UART command encodings and sequencer states.
package uart_dmi_sequencer_pkg;

    localparam int unsigned DMI_W     = 41;
    localparam int unsigned DMI_BYTES = 6;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  op;
    } dmi_req_t;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  err;
    } dmi_resp_t;

    typedef enum logic [7:0] {
        CMD_WRITE = 8'h01,
        CMD_READ  = 8'h02,
        CMD_RESET = 8'h03
    } uart_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_PAYLOAD,
        ST_TAP_WRITE,
        ST_TAP_READ,
        ST_TAP_ACK,
        ST_TX_RESP,
        ST_RESET
    } seq_state_e;

endpackage

// File: rtl/uart_byte_serializer.sv
// Shifts a 41-bit DMI response out as six ready/valid bytes, LSB first;
// the last byte carries only bit 40.
module uart_byte_serializer
    import uart_dmi_sequencer_pkg::*;
(
    input  logic             CLK_I,
    input  logic             RST_NI,
    input  logic             load_i,
    input  logic [DMI_W-1:0] data_i,
    input  logic             ready_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    output logic             done_o
);

    localparam int unsigned SHIFT_W = DMI_BYTES * 8;

    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               valid_q, valid_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        done_o  = 1'b0;
        if (load_i) begin
            shift_d = SHIFT_W'(data_i);
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            if (cnt_q == 3'(DMI_BYTES - 1)) begin
                done_o  = 1'b1;
                valid_d = 1'b0;
            end else begin
                shift_d = shift_q >> 8;
                cnt_d   = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = shift_q[7:0];
    assign valid_o = valid_q;

endmodule

// File: rtl/uart_dmi_sequencer.sv
// Parses UART command bytes into DMI write/read/hard-reset handshakes and
// returns read responses over the UART transmitter.
module uart_dmi_sequencer
    import uart_dmi_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic             CLK_I,
    input  logic             RST_NI,
    input  logic [7:0]       RX_DATA_I,
    input  logic             RX_VALID_I,
    output logic             RX_READY_O,
    output logic [7:0]       TX_DATA_O,
    output logic             TX_VALID_O,
    input  logic             TX_READY_I,
    output logic             TAP_WRITE_O,
    output logic             TAP_READ_O,
    output logic [DMI_W-1:0] DMI_O,
    input  logic [DMI_W-1:0] DMI_I,
    input  logic             DONE_I,
    output logic             DMI_HARD_RESET_O
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_e       state_q, state_d;
    logic [39:0]      payload_q, payload_d;
    dmi_req_t         dmi_q, dmi_d;
    dmi_resp_t        resp_q, resp_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             txf_q, txf_d;
    logic             tx_start_q, tx_start_d;
    logic             rdy_q, rdy_d;
    logic             rx_fire;
    logic             ser_done;

    assign rx_fire = RX_VALID_I && rdy_q;

    always_comb begin
        state_d    = state_q;
        payload_d  = payload_q;
        dmi_d      = dmi_q;
        resp_d     = resp_q;
        bcnt_d     = bcnt_q;
        tmo_d      = tmo_q;
        txf_d      = txf_q;
        tx_start_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    case (RX_DATA_I)
                        CMD_WRITE: begin
                            state_d = ST_RX_PAYLOAD;
                            bcnt_d  = '0;
                            tmo_d   = '0;
                        end
                        CMD_READ:  state_d = ST_TAP_READ;
                        CMD_RESET: begin
                            state_d = ST_RESET;
                            dmi_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RX_PAYLOAD: begin
                if (rx_fire) begin
                    tmo_d = '0;
                    // Sixth byte only contributes bit 40; DMI_O changes just here.
                    if (bcnt_q == 3'(DMI_BYTES - 1)) begin
                        dmi_d   = dmi_req_t'({RX_DATA_I[0], payload_q});
                        state_d = ST_TAP_WRITE;
                    end else begin
                        payload_d = {RX_DATA_I, payload_q[39:8]};
                        bcnt_d    = bcnt_q + 3'd1;
                    end
                end else if (tmo_q >= TMO_W'(TIMEOUT_CYCLES)) begin
                    state_d = ST_IDLE;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_TAP_WRITE: begin
                if (DONE_I) state_d = ST_TAP_ACK;
            end
            ST_TAP_READ: begin
                if (DONE_I) begin
                    resp_d  = dmi_resp_t'(DMI_I);
                    txf_d   = 1'b1;
                    state_d = ST_TAP_ACK;
                end
            end
            ST_TAP_ACK: begin
                if (!DONE_I) begin
                    txf_d = 1'b0;
                    if (txf_q) begin
                        state_d    = ST_TX_RESP;
                        tx_start_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_TX_RESP: begin
                if (ser_done) state_d = ST_IDLE;
            end
            ST_RESET: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Ready is registered from the next state so it stays low while in reset.
    assign rdy_d = (state_d == ST_IDLE) || (state_d == ST_RX_PAYLOAD);

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q    <= ST_IDLE;
            payload_q  <= '0;
            dmi_q      <= '0;
            resp_q     <= '0;
            bcnt_q     <= '0;
            tmo_q      <= '0;
            txf_q      <= 1'b0;
            tx_start_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            payload_q  <= payload_d;
            dmi_q      <= dmi_d;
            resp_q     <= resp_d;
            bcnt_q     <= bcnt_d;
            tmo_q      <= tmo_d;
            txf_q      <= txf_d;
            tx_start_q <= tx_start_d;
            rdy_q      <= rdy_d;
        end
    end

    uart_byte_serializer u_ser (
        .CLK_I   (CLK_I),
        .RST_NI  (RST_NI),
        .load_i  (tx_start_q),
        .data_i  (resp_q),
        .ready_i (TX_READY_I),
        .data_o  (TX_DATA_O),
        .valid_o (TX_VALID_O),
        .done_o  (ser_done)
    );

    assign RX_READY_O       = rdy_q;
    assign TAP_WRITE_O      = (state_q == ST_TAP_WRITE);
    assign TAP_READ_O       = (state_q == ST_TAP_READ);
    assign DMI_HARD_RESET_O = (state_q == ST_RESET);
    assign DMI_O            = dmi_q;

    tap_req_exclusive: assert property (@(posedge CLK_I) disable iff (!RST_NI)
        !(TAP_READ_O && TAP_WRITE_O));

endmodule

// File: tb/tb_uart_dmi_sequencer.sv
// Directed and randomised checks of the UART DMI sequencer against a byte-level model.
module tb_uart_dmi_sequencer;

    localparam int unsigned TMO = 16;

    logic        CLK_I = 1'b0;
    logic        RST_NI;
    logic [7:0]  RX_DATA_I;
    logic        RX_VALID_I;
    logic        RX_READY_O;
    logic [7:0]  TX_DATA_O;
    logic        TX_VALID_O;
    logic        TX_READY_I;
    logic        TAP_WRITE_O;
    logic        TAP_READ_O;
    logic [40:0] DMI_O;
    logic [40:0] DMI_I;
    logic        DONE_I;
    logic        DMI_HARD_RESET_O;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] got[$];

    uart_dmi_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK_I            (CLK_I),
        .RST_NI           (RST_NI),
        .RX_DATA_I        (RX_DATA_I),
        .RX_VALID_I       (RX_VALID_I),
        .RX_READY_O       (RX_READY_O),
        .TX_DATA_O        (TX_DATA_O),
        .TX_VALID_O       (TX_VALID_O),
        .TX_READY_I       (TX_READY_I),
        .TAP_WRITE_O      (TAP_WRITE_O),
        .TAP_READ_O       (TAP_READ_O),
        .DMI_O            (DMI_O),
        .DMI_I            (DMI_I),
        .DONE_I           (DONE_I),
        .DMI_HARD_RESET_O (DMI_HARD_RESET_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #1;
        chk("tap_exclusive", 64'(TAP_READ_O & TAP_WRITE_O), 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        RX_DATA_I  = b;
        RX_VALID_I = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (RX_READY_O) ok = 1'b1;
            tick();
        end
        RX_VALID_I = 1'b0;
        chk("rx_accept", 64'(ok), 64'd1);
    endtask

    // Byte i of a 41-bit DMI word, LSB first.
    function automatic logic [7:0] dmi_byte(input logic [40:0] v, input int i);
        logic [47:0] w;
        w = 48'(v);
        return 8'(w >> (8 * i));
    endfunction

    task automatic collect_tx(input int n, input bit toggle);
        bit         held_v;
        logic [7:0] held;
        int         cyc;
        got.delete();
        held_v = 1'b0;
        held   = '0;
        cyc    = 0;
        while (got.size() < n && cyc < 300) begin
            if (held_v) begin
                chk("tx_hold_valid", 64'(TX_VALID_O), 64'd1);
                chk("tx_hold_data", 64'(TX_DATA_O), 64'(held));
            end
            TX_READY_I = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            held_v = 1'b0;
            if (TX_VALID_O) begin
                if (TX_READY_I) got.push_back(TX_DATA_O);
                else begin
                    held_v = 1'b1;
                    held   = TX_DATA_O;
                end
            end
            tick();
            cyc++;
        end
        TX_READY_I = 1'b0;
        chk("tx_count", 64'(got.size()), 64'(n));
    endtask

    task automatic check_resp(input logic [40:0] r);
        for (int i = 0; i < 6; i++)
            chk($sformatf("tx_byte%0d", i), 64'((i < got.size()) ? got[i] : 8'hxx), 64'(dmi_byte(r, i)));
    endtask

    task automatic write_frame(input logic [40:0] v, input bit rand_hi);
        logic [7:0] b;
        send_byte(8'h01);
        for (int i = 0; i < 6; i++) begin
            b = dmi_byte(v, i);
            if (i == 5 && rand_hi) b[7:1] = 7'($urandom);
            send_byte(b);
        end
        chk("wr_tap_write", 64'(TAP_WRITE_O), 64'd1);
        chk("wr_dmi_o", 64'(DMI_O), 64'(v));
        chk("wr_tap_read", 64'(TAP_READ_O), 64'd0);
        tick();
        chk("wr_hold", 64'(TAP_WRITE_O), 64'd1);
        chk("wr_dmi_stable", 64'(DMI_O), 64'(v));
    endtask

    task automatic write_ack();
        DONE_I = 1'b1;
        tick();
        chk("wr_drop", 64'(TAP_WRITE_O), 64'd0);
        DONE_I = 1'b0;
        tick();
        chk("wr_no_tx", 64'(TX_VALID_O), 64'd0);
        tick();
        chk("wr_no_tx2", 64'(TX_VALID_O), 64'd0);
    endtask

    task automatic do_read(input logic [40:0] r, input bit toggle);
        DMI_I = r;
        send_byte(8'h02);
        chk("rd_tap_read", 64'(TAP_READ_O), 64'd1);
        repeat (3) begin
            tick();
            chk("rd_wait", 64'(TAP_READ_O), 64'd1);
        end
        DONE_I = 1'b1;
        tick();
        chk("rd_drop", 64'(TAP_READ_O), 64'd0);
        DMI_I  = {9'($urandom), $urandom};
        DONE_I = 1'b0;
        tick();
        chk("rd_tx_entry", 64'(TX_VALID_O), 64'd0);
        collect_tx(6, toggle);
        check_resp(r);
        chk("rd_back_idle", 64'(RX_READY_O), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [40:0] v;
        logic [40:0] r;
        RST_NI     = 1'b0;
        RX_DATA_I  = '0;
        RX_VALID_I = 1'b0;
        TX_READY_I = 1'b0;
        DMI_I      = '0;
        DONE_I     = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_rx_ready", 64'(RX_READY_O), 64'd0);
        chk("rst_tx_valid", 64'(TX_VALID_O), 64'd0);
        chk("rst_tx_data", 64'(TX_DATA_O), 64'd0);
        chk("rst_tap_write", 64'(TAP_WRITE_O), 64'd0);
        chk("rst_tap_read", 64'(TAP_READ_O), 64'd0);
        chk("rst_dmi_o", 64'(DMI_O), 64'd0);
        chk("rst_hard", 64'(DMI_HARD_RESET_O), 64'd0);
        RST_NI = 1'b1;
        tick();
        chk("rst_ready_after", 64'(RX_READY_O), 64'd1);

        // Directed write
        write_frame(41'h40_48D1_59E2, 1'b0);
        write_ack();

        // Directed read with stalling transmitter
        do_read(41'h00_0000_0014, 1'b1);

        // Hard-reset command
        send_byte(8'h03);
        chk("hr_pulse", 64'(DMI_HARD_RESET_O), 64'd1);
        chk("hr_not_ready", 64'(RX_READY_O), 64'd0);
        tick();
        chk("hr_single", 64'(DMI_HARD_RESET_O), 64'd0);
        chk("hr_dmi_clear", 64'(DMI_O), 64'd0);
        chk("hr_ready", 64'(RX_READY_O), 64'd1);

        // Partial frame abandoned after the idle timeout
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (TMO + 4) begin
            tick();
            chk("to_no_write", 64'(TAP_WRITE_O), 64'd0);
        end
        chk("to_dmi_kept", 64'(DMI_O), 64'd0);
        v = {9'($urandom), $urandom};
        write_frame(v, 1'b1);
        write_ack();

        // Unknown command is dropped
        send_byte(8'h7F);
        chk("unk_ready", 64'(RX_READY_O), 64'd1);
        chk("unk_no_read", 64'(TAP_READ_O), 64'd0);
        chk("unk_no_hard", 64'(DMI_HARD_RESET_O), 64'd0);
        tick();
        chk("unk_no_write", 64'(TAP_WRITE_O), 64'd0);

        // Stale DONE after a write ack must not complete the following read
        v = {9'($urandom), $urandom};
        write_frame(v, 1'b1);
        DONE_I = 1'b1;
        tick();
        RX_DATA_I  = 8'h02;
        RX_VALID_I = 1'b1;
        repeat (4) begin
            chk("stale_not_ready", 64'(RX_READY_O), 64'd0);
            chk("stale_no_read", 64'(TAP_READ_O), 64'd0);
            tick();
        end
        DONE_I = 1'b0;
        send_byte(8'h02);
        chk("stale_read_up", 64'(TAP_READ_O), 64'd1);
        repeat (4) begin
            tick();
            chk("stale_read_held", 64'(TAP_READ_O), 64'd1);
        end
        r = {9'($urandom), $urandom};
        DMI_I  = r;
        DONE_I = 1'b1;
        tick();
        chk("stale_read_drop", 64'(TAP_READ_O), 64'd0);
        DONE_I = 1'b0;
        collect_tx(6, 1'b1);
        check_resp(r);

        // Asynchronous reset in the middle of a response
        r = {9'($urandom), $urandom};
        DMI_I = r;
        send_byte(8'h02);
        DONE_I = 1'b1;
        tick();
        DONE_I = 1'b0;
        tick();
        collect_tx(2, 1'b0);
        #2 RST_NI = 1'b0;
        #1;
        chk("ar_tx_valid", 64'(TX_VALID_O), 64'd0);
        chk("ar_tx_data", 64'(TX_DATA_O), 64'd0);
        chk("ar_rx_ready", 64'(RX_READY_O), 64'd0);
        chk("ar_dmi_o", 64'(DMI_O), 64'd0);
        chk("ar_taps", 64'({TAP_READ_O, TAP_WRITE_O, DMI_HARD_RESET_O}), 64'd0);
        tick();
        RST_NI = 1'b1;
        tick();
        do_read({9'($urandom), $urandom}, 1'b1);

        // Random mix of transactions
        repeat (6) begin
            v = {9'($urandom), $urandom};
            if ($urandom_range(0, 1) == 1) begin
                write_frame(v, 1'b1);
                write_ack();
            end else begin
                do_read(v, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
